// File: rtl/updown_counter.sv
// Parametrised up/down modulo counter with parallel load, terminal-count decode and wrap pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the end values instead of wrapping.
module updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal_count,
    output logic             wrap
);

    localparam longint unsigned FULL_RANGE = (64'd1 << WIDTH) - 64'd1;

    // Reject illegal configurations at elaboration time
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("updown_counter: WIDTH must be in 1..32");
        end
        if (MAX_COUNT < 1 || MAX_COUNT > FULL_RANGE) begin : g_bad_max
            $error("updown_counter: MAX_COUNT must be in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    assign terminal_count = up_down ? (counter_out == MAX_VAL) : (counter_out == '0);

    // Next count: load beats enable; at an end value either wrap or saturate
    always_comb begin
        count_nxt = counter_out;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (counter_out == MAX_VAL) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    count_nxt = MAX_VAL;
`else
                    count_nxt = '0;
`endif
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = counter_out + ONE;
                end
            end else begin
                if (counter_out == '0) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    count_nxt = '0;
`else
                    count_nxt = MAX_VAL;
`endif
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = counter_out - ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_out <= '0;
            wrap        <= 1'b0;
        end else begin
            counter_out <= count_nxt;
            wrap        <= wrap_nxt;
        end
    end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Parametrised successor to the team's 4-bit enable counter.
- Adds programmable width, an arbitrary modulus, up/down direction, parallel load, a terminal-count decode and a wrap pulse.
- Used as the general-purpose counter/timebase for digital-design blocks, e.g. a decade counter for display drivers or a down-counting timeout timer.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MAX_COUNT, 2**WIDTH-1, highest count value; the counter runs over 0..MAX_COUNT. Legal range 1..2**WIDTH-1. Elaboration error if out of range.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; the counter advances one step per clock while high.
- up_down  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value captured on load.
- counter_out  output  WIDTH  current count, registered.
- terminal_count  output  1  combinational: high when counter_out is at the end value for the current direction.
- wrap  output  1  registered one-cycle pulse marking a boundary crossing.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clock edge.
  - Clears counter_out to 0 and wrap to 0.
  - terminal_count follows its decode (1 if up_down=0, since 0 is the down end value).
- Priority per clock edge: reset > load > enable. With all three low, counter_out holds and wrap is 0.
- Load:
  - counter_out <= load_value.
  - If load_value > MAX_COUNT, counter_out <= MAX_COUNT (clamped).
  - wrap <= 0. Load works regardless of enable; enable is ignored that cycle.
- Count up (enable=1, up_down=1):
  - counter_out < MAX_COUNT: counter_out <= counter_out+1, wrap <= 0.
  - counter_out == MAX_COUNT: counter_out <= 0, wrap <= 1.
- Count down (enable=1, up_down=0):
  - counter_out > 0: counter_out <= counter_out-1, wrap <= 0.
  - counter_out == 0: counter_out <= MAX_COUNT, wrap <= 1.
- wrap timing: high for exactly the one cycle in which counter_out first shows the wrapped value. It stays 0 whenever no wrap occurs in the preceding edge.
- terminal_count: (up_down && counter_out==MAX_COUNT) || (!up_down && counter_out==0). Zero latency, so a direction change updates it in the same cycle.
- Direction change mid-count: takes effect on the next enabled edge. There is no extra step or skipped value.
- Latency: one clock from an enable/load/reset edge to counter_out.
- Arithmetic: the modulus compare is done at full WIDTH. When MAX_COUNT = 2**WIDTH-1, the natural binary wrap and the compare give identical results.
- Reset mid-count or coincident with load: reset wins; counter_out=0, wrap=0.

Optional Feature:
- Macro: UPDOWN_COUNTER_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping: up at MAX_COUNT holds MAX_COUNT, down at 0 holds 0.
  - wrap is replaced in function by a saturation pulse: one cycle high on each enabled edge attempted while already at the end value (the port name is unchanged).
  - Load and reset behaviour are unchanged.
- Not defined: modular wrap behaviour as above.

Test Plan:
- Reset: WIDTH=4, MAX_COUNT=9; assert reset 2 cycles with enable=1 -> counter_out=0, wrap=0. Release, up_down=1 -> 1,2,…,9, then 0 on the 10th enabled edge with wrap=1 for that single cycle; terminal_count=1 only while counter_out=9.
- Down count: load_value=3, load=1 then up_down=0, enable=1 -> 3,2,1,0,9. wrap=1 at the 9; terminal_count=1 at 0.
- Load: load_value=4'd15, MAX_COUNT=9 -> counter_out=9 (clamped). Load and enable both high with load_value=5 -> counter_out=5, no increment.
- Enable/reset interaction: enable toggled 0/1 every 20 time units -> counter_out holds while enable=0. Reset asserted while counter_out=7 and load=1 -> counter_out=0 next edge.
- Full-range default: WIDTH=4, MAX_COUNT=15, up_down=1 -> 15 then 0 with wrap=1. Flip up_down at 0 -> terminal_count rises immediately, next edge gives 15.
- Saturate build (UPDOWN_COUNTER_SATURATE_EN, MAX_COUNT=9): count up to 9, two more enabled edges -> counter_out stays 9 and wrap pulses on each. Down at 0 -> stays 0.
